// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and default parameter values for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester currently holds the memory port
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_MAX_D_STREAK   = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch (read-only)
// and load/store. Data wins arbitration unless it has already taken
// MAX_D_STREAK grants in a row while fetch waited. Each access is bounded by
// TIMEOUT_CYCLES; a stalled memory produces an error response instead of a hang.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   if_req/if_addr          : fetch request (held until if_ack)
//   if_ack/if_rdata/if_err  : fetch response pulse with data and timeout flag
//   d_req/d_we/d_addr/d_wdata/d_wstrb : data request (held until d_ack)
//   d_ack/d_rdata/d_err     : data response pulse with data and timeout flag
//   mem_req/we/addr/wdata/wstrb, mem_ready/rdata : memory side
//   busy, owner             : arbiter status (owner: 0=fetch, 1=data)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned MAX_D_STREAK   = DEF_MAX_D_STREAK,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    owner
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SW         = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);

    // Elaboration-time parameter sanity checks
    if (MAX_D_STREAK < 1) begin : g_chk_streak
        $error("mem_port_arbiter: MAX_D_STREAK must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be >= 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_chk_dw
        $error("mem_port_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    arb_state_t              r_state, w_state_nxt;
    owner_t                  r_owner, w_owner;
    logic [SW-1:0]           r_streak, w_streak;
    logic [TW-1:0]           r_timer, w_timer;
    logic                    r_mem_req, w_mem_req;
    logic                    r_mem_we, w_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata, w_mem_wdata;
    logic [STRB_WIDTH-1:0]   r_mem_wstrb, w_mem_wstrb;
    logic                    r_if_ack, w_if_ack;
    logic                    r_d_ack, w_d_ack;
    logic [DATA_WIDTH-1:0]   r_if_rdata, w_if_rdata;
    logic [DATA_WIDTH-1:0]   r_d_rdata, w_d_rdata;
    logic                    r_if_err, w_if_err;
    logic                    r_d_err, w_d_err;
    logic                    w_grant;
    logic                    w_grant_d;
    logic                    w_timeout;

    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and arbitration decision; fetch wins only once data hit its streak cap
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req || if_req) begin
                    w_grant     = 1'b1;
                    w_grant_d   = d_req && (!if_req || (r_streak < SW'(MAX_D_STREAK)));
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for all registered outputs, streak counter and timeout timer
    always_comb begin
        w_owner     = r_owner;
        w_streak    = r_streak;
        w_timer     = r_timer;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_wstrb = r_mem_wstrb;
        w_if_rdata  = r_if_rdata;
        w_d_rdata   = r_d_rdata;
        w_if_err    = r_if_err;
        w_d_err     = r_d_err;
        w_if_ack    = 1'b0;
        w_d_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_mem_req = 1'b1;
                    w_timer   = TW'(1);
                    if (w_grant_d) begin
                        w_owner     = OWN_D;
                        w_mem_we    = d_we;
                        w_mem_addr  = d_addr;
                        w_mem_wdata = d_wdata;
                        w_mem_wstrb = d_we ? d_wstrb : '0;
                        // Streak only grows while fetch is actually waiting
                        if (if_req) begin
                            w_streak = (r_streak == SW'(MAX_D_STREAK)) ? r_streak
                                                                        : r_streak + SW'(1);
                        end else begin
                            w_streak = '0;
                        end
                    end else begin
                        w_owner     = OWN_IF;
                        w_mem_we    = 1'b0;
                        w_mem_addr  = if_addr;
                        w_mem_wdata = '0;
                        w_mem_wstrb = '0;
                        w_streak    = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    w_mem_req = 1'b0;
                    if (r_owner == OWN_D) begin
                        w_d_rdata = mem_rdata;
                        w_d_err   = 1'b0;
                        w_d_ack   = 1'b1;
                    end else begin
                        w_if_rdata = mem_rdata;
                        w_if_err   = 1'b0;
                        w_if_ack   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_mem_req = 1'b0;
                    if (r_owner == OWN_D) begin
                        w_d_rdata = '0;
                        w_d_err   = 1'b1;
                        w_d_ack   = 1'b1;
                    end else begin
                        w_if_rdata = '0;
                        w_if_err   = 1'b1;
                        w_if_ack   = 1'b1;
                    end
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            RESP: begin
                // Response data is only valid alongside ack
                w_if_rdata = '0;
                w_d_rdata  = '0;
                w_if_err   = 1'b0;
                w_d_err    = 1'b0;
            end
            default: ;
        endcase
    end

    // Output / datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner     <= OWN_IF;
            r_streak    <= '0;
            r_timer     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            r_owner     <= w_owner;
            r_streak    <= w_streak;
            r_timer     <= w_timer;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_wstrb <= w_mem_wstrb;
            r_if_ack    <= w_if_ack;
            r_d_ack     <= w_d_ack;
            r_if_rdata  <= w_if_rdata;
            r_d_rdata   <= w_d_rdata;
            r_if_err    <= w_if_err;
            r_d_err     <= w_d_err;
        end
    end

    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter. Requester agents push
// expected responses into per-side scoreboard queues when a request is
// launched; responses are popped and compared on ack. A simple memory
// responder supplies a configurable wait state or hangs to force timeouts.
module tb_mem_port_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned MAXS    = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          t0;
    } req_t;

    logic          clk;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   acc_cnt = 0;
    int   mem_wait = 0;
    logic mem_hang = 1'b0;
    logic mem_pulse = 1'b0;

    req_t if_todo[$];
    req_t d_todo[$];
    req_t if_exp[$];
    req_t d_exp[$];
    logic grant_log[$];

    mem_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MAX_D_STREAK  (MAXS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic req_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int lat);
        req_t r;
        r.we        = we;
        r.addr      = addr;
        r.wdata     = wdata;
        r.wstrb     = wstrb;
        r.exp_rdata = 32'h0;
        r.exp_err   = 1'b0;
        r.lat       = lat;
        r.t0        = 0;
        return r;
    endfunction

    // Memory responder: ready after mem_wait stalled cycles, never while hung
    initial begin
        int acc;
        acc       = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_pulse) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else if (mem_req && !mem_hang) begin
                if (acc == mem_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_model(mem_addr);
                    acc       = 0;
                end else begin
                    mem_ready = 1'b0;
                    acc       = acc + 1;
                end
            end else begin
                mem_ready = 1'b0;
                acc       = 0;
            end
        end
    end

    // Fetch agent
    initial begin
        req_t it;
        if_req  = 1'b0;
        if_addr = '0;
        forever begin
            @(negedge clk);
            if (if_ack) begin
                chk("if_ack_pending", 32'(if_exp.size() != 0), 32'd1);
                if (if_exp.size() != 0) begin
                    it = if_exp.pop_front();
                    chk("if_rdata", if_rdata, it.exp_rdata);
                    chk("if_err", 32'(if_err), 32'(it.exp_err));
                    if (it.lat >= 0) chk("if_latency", 32'(cyc - it.t0), 32'(it.lat));
                    if (it.exp_err) chk("if_timeout_len", 32'(acc_cnt), 32'(TIMEOUT));
                end
            end
            if (if_todo.size() != 0 && (!if_req || if_ack)) begin
                it           = if_todo.pop_front();
                it.exp_rdata = mem_hang ? 32'h0 : rd_model(it.addr);
                it.exp_err   = mem_hang;
                it.t0        = cyc;
                if_addr      = it.addr;
                if_req       = 1'b1;
                if_exp.push_back(it);
            end else if (if_ack) begin
                if_req = 1'b0;
            end
        end
    end

    // Data agent
    initial begin
        req_t it;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;
        forever begin
            @(negedge clk);
            if (d_ack) begin
                chk("d_ack_pending", 32'(d_exp.size() != 0), 32'd1);
                chk("dual_ack", 32'(if_ack), 32'd0);
                if (d_exp.size() != 0) begin
                    it = d_exp.pop_front();
                    chk("d_rdata", d_rdata, it.exp_rdata);
                    chk("d_err", 32'(d_err), 32'(it.exp_err));
                    if (it.lat >= 0) chk("d_latency", 32'(cyc - it.t0), 32'(it.lat));
                    if (it.exp_err) chk("d_timeout_len", 32'(acc_cnt), 32'(TIMEOUT));
                end
            end
            if (d_todo.size() != 0 && (!d_req || d_ack)) begin
                it           = d_todo.pop_front();
                it.exp_rdata = mem_hang ? 32'h0 : rd_model(it.addr);
                it.exp_err   = mem_hang;
                it.t0        = cyc;
                d_we         = it.we;
                d_addr       = it.addr;
                d_wdata      = it.wdata;
                d_wstrb      = it.wstrb;
                d_req        = 1'b1;
                d_exp.push_back(it);
            end else if (d_ack) begin
                d_req = 1'b0;
            end
        end
    end

    // Memory-side monitor: log grants and check payload every ACCESS cycle
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!prev_req) begin
                    acc_cnt = 0;
                    grant_log.push_back(owner);
                end
                acc_cnt = acc_cnt + 1;
                chk("busy_in_access", 32'(busy), 32'd1);
                if (owner) begin
                    chk("d_owner_pending", 32'(d_exp.size() != 0), 32'd1);
                    if (d_exp.size() != 0) begin
                        chk("mem_we_d", 32'(mem_we), 32'(d_exp[0].we));
                        chk("mem_addr_d", mem_addr, d_exp[0].addr);
                        chk("mem_wstrb_d", 32'(mem_wstrb), d_exp[0].we ? 32'(d_exp[0].wstrb) : 32'd0);
                        if (d_exp[0].we) chk("mem_wdata_d", mem_wdata, d_exp[0].wdata);
                    end
                end else begin
                    chk("if_owner_pending", 32'(if_exp.size() != 0), 32'd1);
                    if (if_exp.size() != 0) begin
                        chk("mem_we_if", 32'(mem_we), 32'd0);
                        chk("mem_addr_if", mem_addr, if_exp[0].addr);
                        chk("mem_wstrb_if", 32'(mem_wstrb), 32'd0);
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((if_todo.size() != 0 || d_todo.size() != 0 || if_exp.size() != 0 ||
                d_exp.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_busy"},      32'(busy),      32'd0);
        chk({p, "_owner"},     32'(owner),     32'd0);
        chk({p, "_mem_req"},   32'(mem_req),   32'd0);
        chk({p, "_mem_we"},    32'(mem_we),    32'd0);
        chk({p, "_mem_addr"},  mem_addr,       32'd0);
        chk({p, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({p, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({p, "_if_ack"},    32'(if_ack),    32'd0);
        chk({p, "_d_ack"},     32'(d_ack),     32'd0);
        chk({p, "_if_rdata"},  if_rdata,       32'd0);
        chk({p, "_d_rdata"},   d_rdata,        32'd0);
        chk({p, "_if_err"},    32'(if_err),    32'd0);
        chk({p, "_d_err"},     32'(d_err),     32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        // Fetch only, zero-wait memory
        @(posedge clk);
        if_todo.push_back(mk(1'b0, 32'h100, 32'h0, 4'h0, 2));
        wait_drain(50);

        // Store with three stall cycles
        mem_wait = 3;
        @(posedge clk);
        d_todo.push_back(mk(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 5));
        wait_drain(50);
        mem_wait = 0;

        // Both sides streaming back-to-back: streak cap lets fetch in every fifth grant
        grant_log.delete();
        @(posedge clk);
        for (int i = 0; i < 2; i++) if_todo.push_back(mk(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, -1));
        for (int i = 0; i < 8; i++) d_todo.push_back(mk(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 4'h0, -1));
        wait_drain(200);
        chk("grant_count", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            chk($sformatf("grant_%0d", i), 32'(grant_log[i]), (i == 4 || i == 9) ? 32'd0 : 32'd1);
        end

        // Timeout on a hung memory, then a normal access
        mem_hang = 1'b1;
        @(posedge clk);
        d_todo.push_back(mk(1'b0, 32'h300, 32'h0, 4'h0, 17));
        wait_drain(100);
        mem_hang = 1'b0;
        @(posedge clk);
        d_todo.push_back(mk(1'b0, 32'h304, 32'h0, 4'h0, 2));
        wait_drain(50);

        // Reset mid-ACCESS: no ack, outputs cleared, held request re-granted
        mem_hang = 1'b1;
        @(posedge clk);
        d_todo.push_back(mk(1'b0, 32'h400, 32'h0, 4'h0, -1));
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        if (d_exp.size() != 0) begin
            d_exp[0].exp_err   = 1'b0;
            d_exp[0].exp_rdata = rd_model(32'h400);
        end
        mem_hang = 1'b0;
        reset_n  = 1'b1;
        wait_drain(50);

        // Stray mem_ready while idle must be ignored
        @(posedge clk);
        mem_pulse = 1'b1;
        @(posedge clk);
        mem_pulse = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_pulse_busy", 32'(busy), 32'd0);
            chk("idle_pulse_if_ack", 32'(if_ack), 32'd0);
            chk("idle_pulse_d_ack", 32'(d_ack), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (read-only) and load/store (read/write).
- Sits between the fetch unit, the data-access path and the memory model.
- Data accesses have priority over fetch; a streak limit prevents fetch starvation.
- A per-access timeout turns a stalled memory into an error response instead of a hang.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; must be a multiple of 8
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits (≥1)
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (≥2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_WIDTH  fetch address
if_ack  out  1  one-cycle completion pulse to fetch
if_rdata  out  DATA_WIDTH  fetch read data; valid only while if_ack=1
if_err  out  1  timeout flag; valid only while if_ack=1
d_req  in  1  data request; payload held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_wstrb  in  DATA_WIDTH/8  store byte enables
d_ack  out  1  one-cycle completion pulse to data side
d_rdata  out  DATA_WIDTH  load data; valid only while d_ack=1
d_err  out  1  timeout flag; valid only while d_ack=1
mem_req  out  1  memory request; held until mem_ready or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_wstrb  out  DATA_WIDTH/8  memory byte enables (all zero for reads)
mem_ready  in  1  memory completes the access in this cycle
mem_rdata  in  DATA_WIDTH  read data; valid when mem_ready=1
busy  out  1  state ≠ IDLE
owner  out  1  current grant: 0=fetch, 1=data; meaningful only when busy=1

Behaviour:
- Reset (reset_n=0 at clk edge) sets all outputs and state as follows:
  - state=IDLE, streak=0, timer=0.
  - All outputs 0, including rdata, mem_* and owner.
  - A transaction in flight is abandoned; no ack is issued.
- FSM states IDLE, ACCESS, RESP.
- IDLE, arbitration (no requests: stay IDLE):
  - d_req only → grant data.
  - if_req only → grant fetch.
  - Both requests and streak<MAX_D_STREAK → grant data.
  - Both requests and streak==MAX_D_STREAK → grant fetch.
- IDLE, on a grant:
  - Register the owner's payload onto the mem_* outputs and set mem_req=1.
  - Fetch grants drive mem_we=0 and mem_wstrb=0.
  - Go to ACCESS; timer=1.
- Streak update at grant time:
  - Data grant with if_req=1 → streak+1, saturating at MAX_D_STREAK.
  - Data grant with if_req=0 → streak=0.
  - Fetch grant → streak=0.
- ACCESS:
  - mem_* held stable.
  - mem_ready=1 → capture mem_rdata into the owner's rdata register, err=0, mem_req=0, go to RESP.
  - Else timer==TIMEOUT_CYCLES → mem_req=0, rdata=0, err=1, go to RESP.
  - Else timer+1.
- RESP:
  - Owner's ack=1 for exactly one cycle, with rdata/err valid; the non-owner's ack stays 0.
  - Next state IDLE. The requester drops req in the cycle after ack, or keeps it high to issue a back-to-back request.
- rdata/err registers clear to 0 when leaving RESP.
- Latency:
  - Zero-wait memory (mem_ready asserted in the first ACCESS cycle): req sampled at edge N → ack high in cycle N+2 → next grant at edge N+3.
  - Throughput is one access per 3 cycles.
- mem_ready while state ≠ ACCESS is ignored.
- Requests are sampled only in IDLE. A request arriving during ACCESS/RESP waits and is not lost while req stays high.
- Payload is captured at grant; changes to requester inputs after grant do not affect mem_*.
- Invalid MAX_D_STREAK/TIMEOUT_CYCLES values are caught by elaboration-time assertions.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - owner_t enum {OWN_IF=0, OWN_D=1}
  - default parameter constants
- No sub-module: FSM, streak counter and timeout timer fit in one module.

Test Plan:
- Fetch only, if_addr=0x100, mem_ready=1 in the first ACCESS cycle with mem_rdata=0x00000013 → if_ack in cycle N+2, if_rdata=0x00000013, if_err=0, mem_we=0.
- Store only, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_ready after 3 cycles → mem_* stable for all 3 cycles, d_ack one cycle after mem_ready, d_err=0.
- Simultaneous if_req/d_req, both held continuously (back-to-back), MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; streak observed 1..4 then reset.
- mem_ready never asserted, TIMEOUT_CYCLES=16 → mem_req drops after 16 ACCESS cycles; d_ack=1, d_err=1, d_rdata=0; the next request proceeds normally.
- reset_n=0 for one cycle mid-ACCESS → next cycle all outputs 0, state IDLE, no ack; a held request is re-granted afterwards.
- mem_ready pulsed while IDLE with no requests → no ack, busy stays 0.
